regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register index width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, meaning number of independent read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ctrl_reset_n  input  1  meaning asynchronous active-low reset.
REQ-007 SHALL have port ctrl_writeEnable  input  1  meaning write request this cycle.
REQ-008 SHALL have port ctrl_writeReg  input  ADDR_WIDTH  meaning write index.
REQ-009 SHALL have port data_writeReg  input  DATA_WIDTH  meaning write data.
REQ-010 SHALL have port ctrl_readReq  input  NUM_READ  meaning per-port read request, bit p for port p.
REQ-011 SHALL have port ctrl_readReg  input  NUM_READ*ADDR_WIDTH  meaning per-port read index, port p at bits [(p+1)*ADDR_WIDTH-1 : p*ADDR_WIDTH].
REQ-012 SHALL have port data_readReg  output  NUM_READ*DATA_WIDTH  meaning per-port read data, port p at bits [(p+1)*DATA_WIDTH-1 : p*DATA_WIDTH].
REQ-013 SHALL have port data_readValid  output  NUM_READ  meaning bit p high for exactly one cycle when port p data is newly updated.

Function
REQ-014 Write: on rising clock with ctrl_writeEnable=1, storage[ctrl_writeReg] SHALL take data_writeReg; no change otherwise.
REQ-015 With ZERO_REG=1, writes to index 0 SHALL be ignored and reads of index 0 SHALL return 0.
REQ-016 Read latency SHALL be exactly 1 cycle: request sampled at edge N -> data_readReg and data_readValid=1 visible after edge N, held through edge N+1.
REQ-017 Without a new request, port p data_readReg SHALL hold its last value; data_readValid[p] SHALL drop to 0.
REQ-018 Write-read bypass: same-edge write and read to the same nonzero index SHALL return the new write data, not the old contents.
REQ-019 Ports SHALL be fully independent; any number of ports SHALL read the same or different indices in the same cycle with no stall.
REQ-020 Read indices SHALL be decoded with a one-hot enable per port; only the selected entry drives that port's data (no internal tristates, no multiple-driver nets).
REQ-021 A read of an index never written since reset SHALL return 0.
REQ-022 ctrl_readReq=0 SHALL leave the port's output register unchanged regardless of ctrl_readReg activity.

Reset
REQ-023 ctrl_reset_n=0 SHALL immediately, independent of clock, clear all storage entries, every data_readReg slice and every data_readValid bit to 0.
REQ-024 Requests or writes presented while ctrl_reset_n=0 SHALL be discarded; the first edge after deassertion SHALL be the first one that acts.
REQ-025 Reset asserted with a read outstanding SHALL cancel it: no data_readValid pulse after deassertion for that request.

Structure
REQ-026 Shared package regfile_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH, NUM_READ and the register-0 index constant.
REQ-027 One sub-module, read_port_sync, SHALL implement a single registered read port (decode, select, bypass, output register, valid); regfile_mp SHALL instantiate it NUM_READ times via generate.
REQ-028 Storage SHALL be flops (DEPTH x DATA_WIDTH), not inferred RAM, so async clear holds.

Verification
REQ-029 Reset, then read all 32 indices on port 0 -> every data = 0x00000000, valid pulse each cycle of request.
REQ-030 Write 0xDEADBEEF to r7, next cycle read r7 on ports 0 and 1 -> both return 0xDEADBEEF one cycle later.
REQ-031 Same edge: write 0x12345678 to r9 and read r9 on port 1 (r9 previously 0xAAAA0000) -> port 1 returns 0x12345678.
REQ-032 Write 0xFFFFFFFF to r0, then read r0 -> returns 0x00000000 (ZERO_REG=1).
REQ-033 Read r3 (=0x5) once, then hold ctrl_readReq=0 while ctrl_readReg toggles -> data stays 0x5, valid low after one pulse.
REQ-034 Assert ctrl_reset_n=0 mid-cycle after a read request -> outputs 0 immediately, no valid pulse after release; re-run with NUM_READ=4, DATA_WIDTH=16.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file.
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_READ   = 2;
  localparam int REG_ZERO_IDX   = 0;
endpackage

// File: rtl/read_port_sync.sv
// One registered read port: one-hot decode, AND-OR select, write bypass, output register and valid.
module read_port_sync
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        rd_req,
  input  logic [ADDR_WIDTH-1:0]       rd_idx,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [DEPTH*DATA_WIDTH-1:0] storage,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid
);
  logic [DEPTH-1:0]      onehot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] next_data;
  logic                  hit_zero;
  logic                  bypass;

  // AND-OR select keeps every entry on a single driven net, no tristate muxing.
  always_comb begin
    onehot = '0;
    onehot[rd_idx] = 1'b1;
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_data |= storage[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{onehot[i]}};
    end
    hit_zero  = (ZERO_REG != 0) && (rd_idx == ADDR_WIDTH'(REG_ZERO_IDX));
    bypass    = wr_en && (wr_idx == rd_idx) && !hit_zero;
    next_data = hit_zero ? '0 : (bypass ? wr_data : sel_data);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= next_data;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file with one write port and NUM_READ independent registered read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ-1:0]            ctrl_readReq,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            data_readValid
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH*DATA_WIDTH-1:0] storage;
  logic                        wr_blocked;

  assign wr_blocked = (ZERO_REG != 0) && (ctrl_writeReg == ADDR_WIDTH'(REG_ZERO_IDX));

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      storage <= '0;
    end else if (ctrl_writeEnable && !wr_blocked) begin
      storage[ctrl_writeReg*DATA_WIDTH +: DATA_WIDTH] <= data_writeReg;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    read_port_sync #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .DEPTH     (DEPTH)
    ) u_rd (
      .clock       (clock),
      .ctrl_reset_n(ctrl_reset_n),
      .rd_req      (ctrl_readReq[p]),
      .rd_idx      (ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_en       (ctrl_writeEnable),
      .wr_idx      (ctrl_writeReg),
      .wr_data     (data_writeReg),
      .storage     (storage),
      .rd_data     (data_readReg[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid    (data_readValid[p])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32b/2-port and a 16b/4-port instance against an array model plus literal checks.
module tb_regfile_mp;
  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  // Instance A: defaults (32-bit, 2 ports)
  logic        we_a;
  logic [4:0]  widx_a;
  logic [31:0] wdata_a;
  logic [1:0]  req_a;
  logic [4:0]  ridx_a [2];
  logic [9:0]  rreg_a;
  logic [63:0] rdata_a;
  logic [1:0]  rvalid_a;
  assign rreg_a = {ridx_a[1], ridx_a[0]};

  regfile_mp u_dut_a (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we_a), .ctrl_writeReg(widx_a), .data_writeReg(wdata_a),
    .ctrl_readReq(req_a), .ctrl_readReg(rreg_a),
    .data_readReg(rdata_a), .data_readValid(rvalid_a)
  );

  // Instance B: 16-bit, 4 ports
  logic        we_b;
  logic [4:0]  widx_b;
  logic [15:0] wdata_b;
  logic [3:0]  req_b;
  logic [4:0]  ridx_b [4];
  logic [19:0] rreg_b;
  logic [63:0] rdata_b;
  logic [3:0]  rvalid_b;
  assign rreg_b = {ridx_b[3], ridx_b[2], ridx_b[1], ridx_b[0]};

  regfile_mp #(.DATA_WIDTH(16), .NUM_READ(4)) u_dut_b (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we_b), .ctrl_writeReg(widx_b), .data_writeReg(wdata_b),
    .ctrl_readReq(req_b), .ctrl_readReg(rreg_b),
    .data_readReg(rdata_b), .data_readValid(rvalid_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: register array semantics, read result = value the register holds after this edge's write
  logic [31:0] mem_a [32];
  logic [31:0] exp_a [2];
  logic        exp_va [2];
  logic [15:0] mem_b [32];
  logic [15:0] exp_b [4];
  logic        exp_vb [4];

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      for (int p = 0; p < 2; p++) begin exp_a[p] = '0; exp_va[p] = 1'b0; end
      for (int p = 0; p < 4; p++) begin exp_b[p] = '0; exp_vb[p] = 1'b0; end
    end else begin
      for (int p = 0; p < 2; p++) begin
        exp_va[p] = req_a[p];
        if (req_a[p]) begin
          if (ridx_a[p] == 0) exp_a[p] = '0;
          else if (we_a && widx_a == ridx_a[p]) exp_a[p] = wdata_a;
          else exp_a[p] = mem_a[ridx_a[p]];
        end
      end
      for (int p = 0; p < 4; p++) begin
        exp_vb[p] = req_b[p];
        if (req_b[p]) begin
          if (ridx_b[p] == 0) exp_b[p] = '0;
          else if (we_b && widx_b == ridx_b[p]) exp_b[p] = wdata_b;
          else exp_b[p] = mem_b[ridx_b[p]];
        end
      end
      if (we_a && widx_a != 0) mem_a[widx_a] = wdata_a;
      if (we_b && widx_b != 0) mem_b[widx_b] = wdata_b;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        check("model_a_data", 64'(rdata_a[p*32 +: 32]), 64'(exp_a[p]));
        check("model_a_valid", 64'(rvalid_a[p]), 64'(exp_va[p]));
      end
      for (int p = 0; p < 4; p++) begin
        check("model_b_data", 64'(rdata_b[p*16 +: 16]), 64'(exp_b[p]));
        check("model_b_valid", 64'(rvalid_b[p]), 64'(exp_vb[p]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_a(input logic [4:0] idx, input logic [31:0] d);
    we_a = 1'b1; widx_a = idx; wdata_a = d;
    step();
    we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] idx, input logic [15:0] d);
    we_b = 1'b1; widx_b = idx; wdata_b = d;
    step();
    we_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we_a = 1'b0; widx_a = '0; wdata_a = '0; req_a = '0; ridx_a[0] = '0; ridx_a[1] = '0;
    we_b = 1'b0; widx_b = '0; wdata_b = '0; req_b = '0;
    for (int p = 0; p < 4; p++) ridx_b[p] = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_a_data", rdata_a, 64'h0);
    check("reset_a_valid", 64'(rvalid_a), 64'h0);
    check("reset_b_data", rdata_b, 64'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // every index reads zero after reset, valid each requested cycle
    for (int i = 0; i < 32; i++) begin
      req_a = 2'b01; ridx_a[0] = 5'(i);
      step();
      check("all_zero_data", 64'(rdata_a[31:0]), 64'h0);
      check("all_zero_valid", 64'(rvalid_a[0]), 64'h1);
    end
    req_a = '0;

    wr_a(5'd7, 32'hDEADBEEF);
    req_a = 2'b11; ridx_a[0] = 5'd7; ridx_a[1] = 5'd7;
    step();
    req_a = '0;
    check("r7_port0", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    check("r7_port1", 64'(rdata_a[63:32]), 64'hDEADBEEF);

    wr_a(5'd9, 32'hAAAA0000);
    wr_a(5'd3, 32'h5);

    // same-edge write and read of r9
    we_a = 1'b1; widx_a = 5'd9; wdata_a = 32'h12345678;
    req_a = 2'b10; ridx_a[1] = 5'd9;
    step();
    we_a = 1'b0; req_a = '0;
    check("bypass_r9", 64'(rdata_a[63:32]), 64'h12345678);

    wr_a(5'd0, 32'hFFFFFFFF);
    req_a = 2'b01; ridx_a[0] = 5'd0;
    step();
    req_a = '0;
    check("r0_zero", 64'(rdata_a[31:0]), 64'h0);

    we_a = 1'b1; widx_a = 5'd0; wdata_a = 32'hCAFEF00D;
    req_a = 2'b10; ridx_a[1] = 5'd0;
    step();
    we_a = 1'b0; req_a = '0;
    check("r0_bypass_zero", 64'(rdata_a[63:32]), 64'h0);

    req_a = 2'b11; ridx_a[0] = 5'd7; ridx_a[1] = 5'd9;
    step();
    req_a = '0;
    check("diff_p0", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    check("diff_p1", 64'(rdata_a[63:32]), 64'h12345678);

    // hold: request once, then index churns with request low
    req_a = 2'b01; ridx_a[0] = 5'd3;
    step();
    check("hold_first", 64'(rdata_a[31:0]), 64'h5);
    check("hold_first_valid", 64'(rvalid_a[0]), 64'h1);
    req_a = '0;
    for (int k = 0; k < 4; k++) begin
      ridx_a[0] = 5'(k * 7 + 1);
      step();
      check("hold_data", 64'(rdata_a[31:0]), 64'h5);
      check("hold_valid", 64'(rvalid_a[0]), 64'h0);
    end

    // 16-bit, 4-port instance
    wr_b(5'd5, 16'hBEEF);
    wr_b(5'd31, 16'h1234);
    req_b = 4'hF; ridx_b[0] = 5'd5; ridx_b[1] = 5'd0; ridx_b[2] = 5'd31; ridx_b[3] = 5'd5;
    step();
    req_b = '0;
    check("b_four_ports", rdata_b, 64'hBEEF_1234_0000_BEEF);
    check("b_valid", 64'(rvalid_b), 64'hF);
    we_b = 1'b1; widx_b = 5'd31; wdata_b = 16'h5A5A;
    req_b = 4'b0100; ridx_b[2] = 5'd31;
    step();
    we_b = 1'b0; req_b = '0;
    check("b_bypass", 64'(rdata_b[47:32]), 64'h5A5A);

    // reset cancels an in-flight read and discards activity while low
    req_a = 2'b11; ridx_a[0] = 5'd7; ridx_a[1] = 5'd9;
    req_b = 4'hF; for (int p = 0; p < 4; p++) ridx_b[p] = 5'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_now_a_data", rdata_a, 64'h0);
    check("rst_now_a_valid", 64'(rvalid_a), 64'h0);
    check("rst_now_b_data", rdata_b, 64'h0);
    check("rst_now_b_valid", 64'(rvalid_b), 64'h0);
    we_a = 1'b1; widx_a = 5'd7; wdata_a = 32'h11111111;
    we_b = 1'b1; widx_b = 5'd5; wdata_b = 16'h2222;
    step();
    step();
    check("rst_hold_a", rdata_a, 64'h0);
    check("rst_hold_b_valid", 64'(rvalid_b), 64'h0);
    we_a = 1'b0; we_b = 1'b0; req_a = '0; req_b = '0;
    rst_n = 1'b1;
    step();
    check("post_rst_a_valid", 64'(rvalid_a), 64'h0);
    check("post_rst_b_valid", 64'(rvalid_b), 64'h0);
    req_a = 2'b01; ridx_a[0] = 5'd7;
    req_b = 4'b0001; ridx_b[0] = 5'd5;
    step();
    req_a = '0; req_b = '0;
    check("post_rst_r7", 64'(rdata_a[31:0]), 64'h0);
    check("post_rst_b_r5", 64'(rdata_b[15:0]), 64'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
